// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter.
// Each accepted payload word goes out one bit per clock on tx_bit as a frame:
// sync word (MSB first), payload (MSB first), optional even-parity bit, then
// GAP_W zero guard cycles. The line idles low between frames.
module sync_frame_tx #(
  parameter int                SYNC_W    = 5,
  parameter logic [SYNC_W-1:0] SYNC      = 5'b10010,
  parameter int                DATA_W    = 8,
  parameter int                PARITY_EN = 1,
  parameter int                GAP_W     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              busy,
  output logic              frame_done
);

  // The single bit counter must reach the longest of the three fields.
  localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_W  = (MAX_SD > GAP_W) ? MAX_SD : GAP_W;
  localparam int CNT_W  = $clog2(MAX_W + 1);

  localparam logic [CNT_W-1:0] SYNC_N = CNT_W'(SYNC_W);
  localparam logic [CNT_W-1:0] DATA_N = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] GAP_N  = CNT_W'(GAP_W);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_t;

  // State mirrors the field whose bit is currently on tx_bit; the counter
  // holds how many bits of that field have already been driven.
  state_t              r_state,  w_state_n;
  logic [CNT_W-1:0]    r_cnt,    w_cnt_n;
  logic [DATA_W-1:0]   r_sh,     w_sh_n;
  logic                r_par,    w_par_n;
  logic                r_tx_bit, w_tx_bit_n;
  logic                r_tx_en,  w_tx_en_n;
  logic                r_done,   w_done_n;
  logic [SYNC_W-1:0]   w_sync_sh;
  logic                w_accept;

  // Next sync bit is the MSB of the pattern shifted by the bits already sent.
  assign w_sync_sh = SYNC << r_cnt;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign busy       = (r_state != S_IDLE);
  assign tx_bit     = r_tx_bit;
  assign tx_en      = r_tx_en;
  assign frame_done = r_done;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sh     <= '0;
      r_par    <= 1'b0;
      r_tx_bit <= 1'b0;
      r_tx_en  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_sh     <= w_sh_n;
      r_par    <= w_par_n;
      r_tx_bit <= w_tx_bit_n;
      r_tx_en  <= w_tx_en_n;
      r_done   <= w_done_n;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // the line bits come straight from flops.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_sh_n     = r_sh;
    w_par_n    = r_par;
    w_tx_bit_n = r_tx_bit;
    w_tx_en_n  = r_tx_en;
    w_done_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sh_n     = in_data;
          w_par_n    = ^in_data;
          w_tx_bit_n = SYNC[SYNC_W-1];
          w_tx_en_n  = 1'b1;
          w_cnt_n    = ONE;
          w_state_n  = S_SYNC;
        end
      end
      S_SYNC: begin
        if (r_cnt < SYNC_N) begin
          w_tx_bit_n = w_sync_sh[SYNC_W-1];
          w_cnt_n    = r_cnt + ONE;
        end else begin
          w_tx_bit_n = r_sh[DATA_W-1];
          w_sh_n     = r_sh << 1;
          w_cnt_n    = ONE;
          w_state_n  = S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt < DATA_N) begin
          w_tx_bit_n = r_sh[DATA_W-1];
          w_sh_n     = r_sh << 1;
          w_cnt_n    = r_cnt + ONE;
        end else if (PARITY_EN != 0) begin
          w_tx_bit_n = r_par;
          w_state_n  = S_PAR;
        end else begin
          w_tx_bit_n = 1'b0;
          w_tx_en_n  = 1'b0;
          w_done_n   = 1'b1;
          w_cnt_n    = ONE;
          w_state_n  = S_GAP;
        end
      end
      S_PAR: begin
        w_tx_bit_n = 1'b0;
        w_tx_en_n  = 1'b0;
        w_done_n   = 1'b1;
        w_cnt_n    = ONE;
        w_state_n  = S_GAP;
      end
      S_GAP: begin
        if (r_cnt < GAP_N) begin
          w_cnt_n = r_cnt + ONE;
        end else begin
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_tx_bit_n = 1'b0;
        w_tx_en_n  = 1'b0;
        w_cnt_n    = '0;
        w_state_n  = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed self-checking bench for sync_frame_tx: default instance plus a
// DATA_W=4, no-parity instance. Inputs driven and outputs sampled 1ns after
// the rising edge.
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, tx_bit, tx_en, busy, frame_done;
  logic [7:0] in_data;
  logic       v4, rdy4, bit4, en4, busy4, done4;
  logic [3:0] d4;

  int checks = 0;
  int errors = 0;

  sync_frame_tx u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_bit(tx_bit), .tx_en(tx_en), .busy(busy),
    .frame_done(frame_done)
  );

  sync_frame_tx #(.DATA_W(4), .PARITY_EN(0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4),
    .in_ready(rdy4), .tx_bit(bit4), .tx_en(en4), .busy(busy4),
    .frame_done(done4)
  );

  always #5 clk = ~clk;

  // Hard stop if something stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; v4 = 1'b0; d4 = '0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (tx_bit !== 1'b0 || tx_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got bit=%b en=%b busy=%b done=%b required 0000",
               tx_bit, tx_en, busy, frame_done);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: got %b required 0", in_ready);
    end
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 50; c++) begin
      step();
      checks++;
      if (tx_bit !== 1'b0 || tx_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold c%0d: got bit=%b en=%b busy=%b rdy=%b required 0001",
                 c, tx_bit, tx_en, busy, in_ready);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [13:0] e;
    e = 14'b10010_10100101_0;
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if (tx_bit !== e[13] || tx_en !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_bit c%0d: got bit=%b en=%b busy=%b required bit=%b en=1 busy=1",
                 c, tx_bit, tx_en, busy, e[13]);
      end
      e = e << 1;
      step();
    end
    checks++;
    if (tx_bit !== 1'b0 || tx_en !== 1'b0 || frame_done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_gap c15: got bit=%b en=%b done=%b rdy=%b required 0010",
               tx_bit, tx_en, frame_done, in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle c16: got rdy=%b done=%b busy=%b required 100",
               in_ready, frame_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] win;
    int hits;
    win = '0; hits = 0;
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    for (int c = 1; c <= 33; c++) begin
      if (c == 1)  in_data  = 8'h01;
      if (c == 17) in_valid = 1'b0;
      win = {win[3:0], tx_bit};
      if (win == 5'b10010) hits++;
      if (c == 14) begin
        checks++;
        if (tx_bit !== 1'b0 || tx_en !== 1'b1) begin
          errors++; $display("FAIL b2b_parity1: got bit=%b en=%b required bit=0 en=1", tx_bit, tx_en);
        end
      end
      if (c == 15 || c == 31) begin
        checks++;
        if (frame_done !== 1'b1) begin
          errors++; $display("FAIL b2b_done c%0d: got %b required 1", c, frame_done);
        end
      end
      if (c == 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready c16: got %b required 1", in_ready);
        end
      end
      if (c == 17) begin
        checks++;
        if (tx_bit !== 1'b1 || tx_en !== 1'b1) begin
          errors++; $display("FAIL b2b_second_start c17: got bit=%b en=%b required 11", tx_bit, tx_en);
        end
      end
      if (c == 30) begin
        checks++;
        if (tx_bit !== 1'b1 || tx_en !== 1'b1) begin
          errors++; $display("FAIL b2b_parity2: got bit=%b en=%b required 11", tx_bit, tx_en);
        end
      end
      step();
    end
    checks++;
    if (hits != 2) begin
      errors++; $display("FAIL b2b_sync_hits: got %0d required 2", hits);
    end
  endtask

  task automatic test_payload_change();
    logic [13:0] e;
    e = 14'b10010_00111100_0;
    in_data = 8'h3C; in_valid = 1'b1;
    step();
    for (int c = 1; c <= 16; c++) begin
      in_valid = (c >= 2 && c <= 10);
      in_data  = in_valid ? 8'hC3 : 8'h3C;
      if (c <= 14) begin
        checks++;
        if (tx_bit !== e[13] || tx_en !== 1'b1) begin
          errors++;
          $display("FAIL change_bit c%0d: got bit=%b en=%b required bit=%b en=1", c, tx_bit, tx_en, e[13]);
        end
        e = e << 1;
      end
      checks++;
      if (in_ready !== (c == 16)) begin
        errors++; $display("FAIL change_ready c%0d: got %b required %b", c, in_ready, (c == 16));
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [13:0] e;
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) step();
    rst = 1'b1;
    #1;
    checks++;
    if (tx_bit !== 1'b0 || tx_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got bit=%b en=%b busy=%b done=%b required 0000",
               tx_bit, tx_en, busy, frame_done);
    end
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midrst_release: got rdy=%b done=%b required 10", in_ready, frame_done);
    end
    e = 14'b10010_01011010_0;
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if (tx_bit !== e[13] || tx_en !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL midrst_frame c%0d: got bit=%b en=%b done=%b required bit=%b en=1 done=0",
                 c, tx_bit, tx_en, frame_done, e[13]);
      end
      e = e << 1;
      step();
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL midrst_done c15: got %b required 1", frame_done);
    end
    step();
  endtask

  task automatic test_no_parity();
    logic [8:0] e;
    e = 9'b10010_1011;
    d4 = 4'b1011; v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (bit4 !== e[8] || en4 !== 1'b1) begin
        errors++;
        $display("FAIL nopar_bit c%0d: got bit=%b en=%b required bit=%b en=1", c, bit4, en4, e[8]);
      end
      e = e << 1;
      step();
    end
    checks++;
    if (done4 !== 1'b1 || en4 !== 1'b0 || bit4 !== 1'b0 || rdy4 !== 1'b0) begin
      errors++;
      $display("FAIL nopar_gap c10: got done=%b en=%b bit=%b rdy=%b required 1000",
               done4, en4, bit4, rdy4);
    end
    step();
    checks++;
    if (rdy4 !== 1'b1 || done4 !== 1'b0) begin
      errors++; $display("FAIL nopar_ready c11: got rdy=%b done=%b required 10", rdy4, done4);
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_single_frame();
    test_back_to_back();
    test_payload_change();
    test_reset_mid_frame();
    test_no_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_frame_tx.md
# sync_frame_tx

Serial frame transmitter. Accepts a parallel payload word over a valid/ready handshake and shifts it out one bit per clock as a frame: a fixed sync word (default 10010), the payload MSB first, an optional even-parity bit, then a guard gap of zeros. It is the transmit side of the serial link whose receive side is the 10010 sequence detector. It sits between the payload source and the single-bit line driver.

## Interface
- SYNC_W, 5: sync word width; legal range 1..16
- SYNC, 5'b10010: sync pattern, sent MSB first; MSB must be 1
- DATA_W, 8: payload width; legal range 1..32
- PARITY_EN, 1: 1 appends an even-parity bit; 0 omits it
- GAP_W, 1: number of zero guard cycles after each frame; legal range 1..15
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  payload present on in_data
- in_data  in  DATA_W  payload word
- in_ready  out  1  block can accept a word this cycle
- tx_bit  out  1  serial line bit (registered)
- tx_en  out  1  high while tx_bit carries a frame bit (registered)
- busy  out  1  high whenever the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse after the last frame bit (registered)

## Operation
- FSM states: IDLE, SYNC, DATA, PAR, GAP. One bit counter, sized for the largest of SYNC_W, DATA_W, GAP_W. One DATA_W-bit shift register. One parity register.
- IDLE: in_ready = 1 (forced to 0 while rst is high). When in_valid & in_ready: load the shift register with in_data, load parity = ^in_data, set tx_bit <= SYNC[SYNC_W-1], set tx_en <= 1, go to SYNC.
- SYNC: sends SYNC bits MSB to LSB, one per cycle. After the LSB, go to DATA.
- DATA: tx_bit = shift register MSB, shifting left each cycle. After DATA_W bits, go to PAR if PARITY_EN, else GAP.
- PAR: sends one bit = parity register. The total number of ones over payload plus parity is even. Then go to GAP.
- GAP: tx_bit = 0 and tx_en = 0 for GAP_W cycles, then go to IDLE. frame_done = 1 in the first GAP cycle only.
- in_data is sampled only at the acceptance edge. Changes on in_data or in_valid during a frame have no effect.
- in_ready = 0 in every non-IDLE state. No word is buffered during a frame.
- busy = (state != IDLE).
- Reset values: state IDLE, tx_bit 0, tx_en 0, frame_done 0, counter 0, shift register 0, parity 0. Reset asserted mid-frame aborts the frame immediately, with no frame_done pulse. After reset release, in_ready = 1 in the same cycle.
- Outside frames the line idles at tx_bit = 0. Because SYNC MSB is 1, the first frame bit is always a 0→1 edge.

## Timing
- Let cycle 0 be the acceptance edge. Frame bits appear on tx_bit/tx_en in cycles 1..L.
  - L = SYNC_W + DATA_W + PARITY_EN; L = 14 at defaults.
- Gap occupies cycles L+1..L+GAP_W. frame_done is high in cycle L+1.
- IDLE, with in_ready = 1, is reached in cycle L+GAP_W+1.
- Minimum frame period is L+GAP_W+1 cycles: 16 at defaults, when in_valid is held high.
- Latency from acceptance to first bit is 1 cycle. From acceptance to frame_done it is L+1 cycles.

## Test plan
- Single frame, defaults, in_data = 8'hA5 accepted at cycle 0:
  - tx_bit cycles 1..14 = 1,0,0,1,0, 1,0,1,0,0,1,0,1, 0; tx_en = 1 in cycles 1..14.
  - cycle 15: tx_bit = 0, tx_en = 0, frame_done = 1. in_ready returns to 1 at cycle 16.
- Back-to-back frames, in_valid held high with 8'hFF then 8'h01:
  - first frame's parity bit = 0; second frame's first sync bit appears at cycle 17 and its parity bit = 1.
  - a detector on tx_bit reports exactly two sync hits.
- Payload change mid-frame: accept 8'h3C, then drive in_data = 8'hC3 with in_valid = 1 during cycles 2..10.
  - transmitted payload stays 0,0,1,1,1,1,0,0; in_ready stays 0 until cycle 16.
- Reset mid-frame: assert rst during cycle 7 of an 8'hA5 frame.
  - tx_bit, tx_en, busy = 0 immediately; no frame_done pulse.
  - after release, in_ready = 1 and a new 8'h5A frame transmits correctly.
- PARITY_EN = 0, DATA_W = 4, in_data = 4'b1011:
  - cycles 1..9 = 1,0,0,1,0,1,0,1,1; frame_done in cycle 10; in_ready = 1 at cycle 11.
- Idle hold: in_valid = 0 for 50 cycles after reset → tx_bit = 0, tx_en = 0, busy = 0, in_ready = 1 throughout.
